ipg_rx_demux: RTL and testbench

IPG_RX_DEMUX -- requirements
Module: ipg_rx_demux

---
 rtl/ipg_rx_demux.sv | 173 +++++++++++++++++
 tb/tb_ipg_rx_demux.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipg_rx_demux.sv
// ipg_rx_demux: realigns a received IPG bit stream into messages, strips the
// message-type tag and steers each emitted chunk to one of three message types.
// Malformed, unknown or oversize messages are dropped and counted.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   rx_ipg_data  received chunk, valid bits MSB-aligned at [63 -: rx_len]
//   rx_len       valid bit count of rx_ipg_data (0 = no data)
//   rx_sof       rx_ipg_data[63] starts a new message (ignored when rx_len = 0)
//   out_data     realigned message chunk, MSB-aligned, zero below out_len
//   out_len      valid bits in out_data (0 = no emission)
//   rresp_valid  emission belongs to a read response   (tag 4'hA)
//   wreq_valid   emission belongs to a write request   (tag 4'h5)
//   rreq_valid   emission belongs to a read request    (tag 4'h3)
//   msg_abort    one-cycle pulse when a new rx_sof truncates the current message
//   drop_cnt     saturating count of dropped messages
module ipg_rx_demux #(
    parameter int unsigned MAX_PAYLOAD = 512,
    parameter int unsigned TAG_BITS    = 4,
    parameter int unsigned HDR_BITS    = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rx_ipg_data,
    input  logic [5:0]  rx_len,
    input  logic        rx_sof,
    output logic [63:0] out_data,
    output logic [5:0]  out_len,
    output logic        rresp_valid,
    output logic        wreq_valid,
    output logic        rreq_valid,
    output logic        msg_abort,
    output logic [15:0] drop_cnt
);

    localparam int unsigned BUF_W       = 128;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned REM_W       = 10;
    localparam int unsigned LEN_FIELD_W = 16;
    localparam int unsigned MAX_EMIT    = 63;
    localparam logic [63:0] ONES        = '1;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DROP} state_t;
    typedef enum logic [1:0] {K_NONE, K_RRESP, K_WREQ, K_RREQ} kind_t;

    // Message type from the tag; K_NONE marks an unknown tag.
    function automatic kind_t decode_tag(input logic [TAG_BITS-1:0] t);
        kind_t k;
        k = K_NONE;
        if (t == TAG_BITS'(4'hA)) k = K_RRESP;
        if (t == TAG_BITS'(4'h5)) k = K_WREQ;
        if (t == TAG_BITS'(4'h3)) k = K_RREQ;
        return k;
    endfunction

    state_t             state, state_nx;
    kind_t              kind, kind_nx, in_kind;
    logic [BUF_W-1:0]   rbuf, rbuf_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [REM_W-1:0]   rem, rem_nx;
    logic [63:0]        app_data;
    logic [5:0]         app_n;
    logic [LEN_FIELD_W-1:0] hdr_len;
    logic [REM_W-1:0]   emit_n;
    logic [63:0]        emit_data;
    logic               sof, abort_nx, drop_inc;

    assign sof     = rx_sof && (rx_len != '0);
    assign in_kind = decode_tag(rx_ipg_data[63 -: TAG_BITS]);

    // Next-state datapath: accept chunk, parse header, carve out one emission.
    always_comb begin
        state_nx  = state;
        rbuf_nx   = rbuf;
        cnt_nx    = cnt;
        rem_nx    = rem;
        kind_nx   = kind;
        app_data  = '0;
        app_n     = '0;
        abort_nx  = 1'b0;
        drop_inc  = 1'b0;
        hdr_len   = '0;
        emit_n    = '0;
        emit_data = '0;

        // A start-of-frame restarts from IDLE whatever state we were in.
        if (sof) begin
            abort_nx = (state == HDR) || (state == BODY);
            rbuf_nx  = '0;
            cnt_nx   = '0;
            rem_nx   = '0;
            kind_nx  = K_NONE;
            if (32'(rx_len) < TAG_BITS || in_kind == K_NONE) begin
                state_nx = DROP;
                drop_inc = 1'b1;
            end else begin
                state_nx = HDR;
                kind_nx  = in_kind;
                app_data = rx_ipg_data << TAG_BITS;
                app_n    = 6'(32'(rx_len) - TAG_BITS);
            end
        end else if (rx_len != '0 && (state == HDR || state == BODY)) begin
            app_data = rx_ipg_data;
            app_n    = rx_len;
        end

        // Append the masked chunk directly after the leftover bits.
        rbuf_nx = rbuf_nx | ({app_data & ~(ONES >> app_n), 64'b0} >> cnt_nx);
        cnt_nx  = cnt_nx + CNT_W'(app_n);

        if (state_nx == HDR && 32'(cnt_nx) >= HDR_BITS) begin
            hdr_len = rbuf_nx[BUF_W-1 -: LEN_FIELD_W];
            if (32'(hdr_len) > MAX_PAYLOAD) begin
                state_nx = DROP;
                drop_inc = 1'b1;
                rbuf_nx  = '0;
                cnt_nx   = '0;
            end else begin
                rem_nx   = REM_W'(HDR_BITS + 32'(hdr_len));
                state_nx = BODY;
            end
        end

        // Emit min(buffered, remaining, 63) bits; leftovers past the end are junk.
        if (state_nx == BODY && cnt_nx != '0) begin
            emit_n = REM_W'(cnt_nx);
            if (rem_nx < emit_n) emit_n = rem_nx;
            if (emit_n > REM_W'(MAX_EMIT)) emit_n = REM_W'(MAX_EMIT);
            emit_data = rbuf_nx[BUF_W-1 -: 64] & ~(ONES >> emit_n);
            rbuf_nx   = rbuf_nx << emit_n;
            cnt_nx    = cnt_nx - CNT_W'(emit_n);
            rem_nx    = rem_nx - emit_n;
            if (rem_nx == '0) begin
                state_nx = IDLE;
                rbuf_nx  = '0;
                cnt_nx   = '0;
            end
        end
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            kind        <= K_NONE;
            rbuf        <= '0;
            cnt         <= '0;
            rem         <= '0;
            out_data    <= '0;
            out_len     <= '0;
            rresp_valid <= 1'b0;
            wreq_valid  <= 1'b0;
            rreq_valid  <= 1'b0;
            msg_abort   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nx;
            kind        <= kind_nx;
            rbuf        <= rbuf_nx;
            cnt         <= cnt_nx;
            rem         <= rem_nx;
            out_data    <= emit_data;
            out_len     <= 6'(emit_n);
            rresp_valid <= (emit_n != '0) && (kind_nx == K_RRESP);
            wreq_valid  <= (emit_n != '0) && (kind_nx == K_WREQ);
            rreq_valid  <= (emit_n != '0) && (kind_nx == K_RREQ);
            msg_abort   <= abort_nx;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ipg_rx_demux.sv
// Testbench for ipg_rx_demux: a bit-queue reference model pushes the expected
// output of every driven cycle to a scoreboard, popped one cycle later.
module tb_ipg_rx_demux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rx_ipg_data = '0;
    logic [5:0]  rx_len = '0;
    logic        rx_sof = 1'b0;
    logic [63:0] out_data;
    logic [5:0]  out_len;
    logic        rresp_valid, wreq_valid, rreq_valid, msg_abort;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    ipg_rx_demux #(.MAX_PAYLOAD(512), .TAG_BITS(4), .HDR_BITS(28)) dut (
        .clk(clk), .reset(reset), .rx_ipg_data(rx_ipg_data), .rx_len(rx_len),
        .rx_sof(rx_sof), .out_data(out_data), .out_len(out_len),
        .rresp_valid(rresp_valid), .wreq_valid(wreq_valid), .rreq_valid(rreq_valid),
        .msg_abort(msg_abort), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  len;
        logic [2:0]  vld;     // {rresp, wreq, rreq}
        logic        abort;
        logic [15:0] drop;
    } exp_t;

    typedef enum int {M_IDLE, M_HDR, M_BODY, M_DROP} mstate_t;

    exp_t    exp_q[$];
    int      n_checks = 0;
    int      n_err = 0;
    mstate_t m_state = M_IDLE;
    bit      mq[$];
    bit      msg[$];
    int      m_rem = 0;
    int      m_drop = 0;
    logic [3:0] m_tag = '0;
    int      obs_emits, obs_bits, obs_aborts, obs_maxlen;
    logic [2:0] obs_vld;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one input chunk -> expected registered output.
    task automatic model_step(input logic [63:0] d, input int len, input logic s, output exp_t e);
        int L;
        int n;
        logic [3:0] tg;
        e = '0;
        tg = d[63:60];
        if (s && len != 0) begin
            if (m_state == M_HDR || m_state == M_BODY) e.abort = 1'b1;
            mq.delete();
            m_rem = 0;
            if (len < 4 || !(tg == 4'hA || tg == 4'h5 || tg == 4'h3)) begin
                m_state = M_DROP;
                if (m_drop < 65535) m_drop++;
            end else begin
                m_tag = tg;
                m_state = M_HDR;
                for (int i = 4; i < len; i++) mq.push_back(d[63-i]);
            end
        end else if (len != 0 && (m_state == M_HDR || m_state == M_BODY)) begin
            for (int i = 0; i < len; i++) mq.push_back(d[63-i]);
        end
        if (m_state == M_HDR && mq.size() >= 28) begin
            L = 0;
            for (int i = 0; i < 16; i++) L = L * 2 + int'(mq[i]);
            if (L > 512) begin
                mq.delete();
                if (m_drop < 65535) m_drop++;
                m_state = M_DROP;
            end else begin
                m_rem = 28 + L;
                m_state = M_BODY;
            end
        end
        if (m_state == M_BODY && mq.size() > 0) begin
            n = mq.size();
            if (m_rem < n) n = m_rem;
            if (n > 63) n = 63;
            for (int i = 0; i < n; i++) e.data[63-i] = mq.pop_front();
            e.len = 6'(n);
            e.vld = (m_tag == 4'hA) ? 3'b100 : (m_tag == 4'h5) ? 3'b010 : 3'b001;
            m_rem -= n;
            if (m_rem == 0) begin
                mq.delete();
                m_state = M_IDLE;
            end
        end
        e.drop = 16'(m_drop);
    endtask

    task automatic compare_out();
        exp_t e;
        e = exp_q.pop_front();
        check_eq("out_len", 64'(out_len), 64'(e.len));
        check_eq("out_data", out_data, e.data);
        check_eq("valids", 64'({rresp_valid, wreq_valid, rreq_valid}), 64'(e.vld));
        check_eq("msg_abort", 64'(msg_abort), 64'(e.abort));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(e.drop));
        if (out_len != '0) begin
            obs_emits++;
            obs_bits += int'(out_len);
            if (int'(out_len) > obs_maxlen) obs_maxlen = int'(out_len);
        end
        obs_vld |= {rresp_valid, wreq_valid, rreq_valid};
        if (msg_abort) obs_aborts++;
    endtask

    task automatic drive(input logic [63:0] d, input logic [5:0] l, input logic s);
        exp_t e;
        rx_ipg_data = d;
        rx_len = l;
        rx_sof = s;
        model_step(d, int'(l), s, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic clear_obs();
        obs_emits = 0; obs_bits = 0; obs_aborts = 0; obs_maxlen = 0; obs_vld = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_state = M_IDLE; mq.delete(); m_rem = 0; m_drop = 0; exp_q.delete();
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_len", 64'(out_len), 64'd0);
        check_eq("rst_valids", 64'({rresp_valid, wreq_valid, rreq_valid, msg_abort}), 64'd0);
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        reset = 1'b0;
        rx_len = '0;
        rx_sof = 1'b0;
    endtask

    // Message = tag, 16-bit length, 12-bit address, L payload bits.
    task automatic build_msg(input logic [3:0] tg, input int L);
        logic [15:0] lv;
        lv = 16'(L);
        msg.delete();
        for (int i = 3; i >= 0; i--) msg.push_back(tg[i]);
        for (int i = 15; i >= 0; i--) msg.push_back(lv[i]);
        for (int i = 0; i < 12 + L; i++) msg.push_back(1'($urandom));
    endtask

    // Send msg in chunks (garbage below the valid bits), gap idle cycles after each.
    task automatic send_stream(input int first_sz, input int csz, input int gap, input int maxc);
        int pos;
        int k;
        int n;
        logic [63:0] d;
        pos = 0;
        k = 0;
        while (pos < msg.size() && (maxc == 0 || k < maxc)) begin
            n = (k == 0) ? first_sz : csz;
            if (n > msg.size() - pos) n = msg.size() - pos;
            d = {$urandom(), $urandom()};
            for (int i = 0; i < n; i++) d[63-i] = msg[pos+i];
            drive(d, 6'(n), k == 0);
            pos += n;
            k++;
            repeat (gap) drive({$urandom(), $urandom()}, 6'd0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        apply_reset();

        // Single-chunk read response, L=16: one 44-bit emission.
        clear_obs();
        build_msg(4'hA, 16);
        send_stream(48, 48, 0, 0);
        check_eq("r035_bits", 64'(obs_bits), 64'd44);
        check_eq("r035_emits", 64'(obs_emits), 64'd1);
        check_eq("r035_vld", 64'(obs_vld), 64'b100);

        // Header split across idle cycles; 20 trailing bits discarded.
        clear_obs();
        build_msg(4'h5, 8);
        for (int i = 0; i < 20; i++) msg.push_back(1'($urandom));
        send_stream(20, 40, 3, 0);
        check_eq("r036_emits", 64'(obs_emits), 64'd1);
        check_eq("r036_bits", 64'(obs_bits), 64'd36);
        check_eq("r036_vld", 64'(obs_vld), 64'b010);

        // Unknown tag dropped; nothing until the next sof; then a read request.
        clear_obs();
        build_msg(4'hF, 16);
        send_stream(48, 48, 0, 0);
        drive({$urandom(), $urandom()}, 6'd48, 1'b0);
        check_eq("r037_drop", 64'(drop_cnt), 64'd1);
        check_eq("r037_quiet", 64'(obs_emits), 64'd0);
        build_msg(4'h3, 100);
        send_stream(50, 50, 1, 0);
        check_eq("r037_bits", 64'(obs_bits), 64'd128);
        check_eq("r037_vld", 64'(obs_vld), 64'b001);

        // Oversize payload: dropped, DROP held across the remaining chunks.
        clear_obs();
        build_msg(4'hA, 600);
        send_stream(40, 40, 0, 0);
        check_eq("r038_drop", 64'(drop_cnt), 64'd2);
        check_eq("r038_quiet", 64'(obs_emits), 64'd0);
        drive({$urandom(), $urandom()}, 6'd3, 1'b1);
        check_eq("short_sof_drop", 64'(drop_cnt), 64'd3);

        // Truncated write request aborted by a new read response.
        build_msg(4'h5, 200);
        send_stream(30, 30, 0, 3);
        clear_obs();
        build_msg(4'hA, 40);
        send_stream(63, 63, 0, 0);
        check_eq("r039_aborts", 64'(obs_aborts), 64'd1);
        check_eq("r039_bits", 64'(obs_bits), 64'd68);
        check_eq("r039_vld", 64'(obs_vld), 64'b100);

        // Maximum payload in 63-bit chunks.
        clear_obs();
        build_msg(4'hA, 512);
        send_stream(63, 63, 0, 0);
        check_eq("r040_bits", 64'(obs_bits), 64'd540);
        check_eq("r040_maxlen", 64'(obs_maxlen), 64'd63);
        check_eq("r040_emits", 64'(obs_emits), 64'd9);

        // Reset mid-message, then a non-sof chunk must not emit.
        build_msg(4'hA, 512);
        send_stream(63, 63, 0, 3);
        rx_ipg_data = {$urandom(), $urandom()};
        rx_len = 6'd63;
        rx_sof = 1'b0;
        apply_reset();
        clear_obs();
        drive({$urandom(), $urandom()}, 6'd63, 1'b0);
        check_eq("post_rst_quiet", 64'(obs_emits), 64'd0);

        // Randomised mix of tags, lengths, chunkings, gaps and truncations.
        for (int it = 0; it < 25; it++) begin
            logic [3:0] tg;
            int L;
            case ($urandom_range(0, 5))
                0: tg = 4'hA;
                1: tg = 4'h5;
                2: tg = 4'h3;
                3: tg = 4'hF;
                default: tg = 4'($urandom);
            endcase
            L = ($urandom_range(0, 7) == 0) ? int'($urandom_range(513, 700)) : int'($urandom_range(0, 300));
            build_msg(tg, L);
            send_stream(int'($urandom_range(1, 63)), int'($urandom_range(8, 63)),
                        int'($urandom_range(0, 2)),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        repeat (2) drive('0, 6'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
